// File: rtl/updown_ctrl_pkg.sv
// Shared types and default sizing for the up/down direction controller and its counter.
package updown_ctrl_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_state_t;

  localparam int DEF_CNT_W       = 3;
  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic dir_state_t flip_dir(input dir_state_t d);
    return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/updown_dir_ctrl_if.sv
// Signals exchanged between the direction controller and its environment (button, switch, counter).
interface updown_dir_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             btn;
  logic             auto_mode;
  logic [CNT_W-1:0] q_fb;
  logic             up_down;
  logic             btn_pulse;
  logic             dir_chg;

  modport master (
    output btn, auto_mode, q_fb,
    input  up_down, btn_pulse, dir_chg
  );

  modport slave (
    input  btn, auto_mode, q_fb,
    output up_down, btn_pulse, dir_chg
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchroniser plus counting debouncer for one asynchronous, bouncy input level.
module btn_debounce #(
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db_level,
  output logic rise_pulse
);

  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q [SYNC_STAGES];
  logic          btn_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic          pulse_q;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) sync_q[gi] <= 1'b0;
        else       sync_q[gi] <= raw;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (reset) sync_q[gi] <= 1'b0;
        else       sync_q[gi] <= sync_q[gi-1];
      end
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // The flip lands on the edge that would make the mismatch count reach DB_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (btn_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      db_d  = ~db_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
      pulse_q  <= db_q & ~db_dly_q;
    end
  end

  assign db_level   = db_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction FSM driving the counter's up_down: button toggles, and in auto mode it ping-pongs 0..MAX..0.
module updown_dir_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic              clk,
  input logic              reset,
  updown_dir_ctrl_if.slave bus
);

  // Turn one value early: the counter steps on the same edge the new direction lands.
  localparam logic [CNT_W-1:0] TURN_HI = CNT_W'((1 << CNT_W) - 2);
  localparam logic [CNT_W-1:0] TURN_LO = CNT_W'(1);

  logic                   btn_db;
  logic                   btn_pulse;
  logic                   unused_btn_db;
  logic [SYNC_STAGES-1:0] auto_sync_q;
  logic                   auto_s;
  logic                   at_turn;
  dir_state_t             state_q, state_d;
  logic                   dir_chg_q;

  btn_debounce #(
    .DB_CYCLES  (DB_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_db (
    .clk       (clk),
    .reset     (reset),
    .raw       (bus.btn),
    .db_level  (btn_db),
    .rise_pulse(btn_pulse)
  );

  assign unused_btn_db = btn_db;

  always_ff @(posedge clk) begin
    if (reset) auto_sync_q <= '0;
    else       auto_sync_q <= {auto_sync_q[SYNC_STAGES-2:0], bus.auto_mode};
  end

  assign auto_s = auto_sync_q[SYNC_STAGES-1];

  // A press coinciding with a terminal reversal is absorbed: only one toggle happens.
  always_comb begin
    at_turn = 1'b0;
    state_d = state_q;
    if (auto_s) begin
      at_turn = (state_q == DIR_UP)   ? (bus.q_fb == TURN_HI)
                                      : (bus.q_fb == TURN_LO);
    end
    if (at_turn || btn_pulse) begin
      state_d = flip_dir(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIR_UP;
      dir_chg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_chg_q <= (state_d != state_q);
    end
  end

  assign bus.up_down   = (state_q == DIR_UP);
  assign bus.btn_pulse = btn_pulse;
  assign bus.dir_chg   = dir_chg_q;

endmodule
